// File: rtl/change_dispense_sequencer_if.sv
// Change dispenser bus: vending-controller command/status and coin-ejector handshake.
// slave = sequencer side, master = controller/ejector side.
interface change_dispense_sequencer_if #(
    parameter int AMT_W = 6
);
    logic             start;
    logic [AMT_W-1:0] change_amt;
    logic [4:0]       tube_empty;
    logic             coin_ack;
    logic             fault_clr;
    logic [4:0]       coin_req;
    logic             busy;
    logic             done;
    logic             short;
    logic             fault;
    logic [AMT_W-1:0] remain;

    modport slave (
        input  start, change_amt, tube_empty, coin_ack, fault_clr,
        output coin_req, busy, done, short, fault, remain
    );

    modport master (
        output start, change_amt, tube_empty, coin_ack, fault_clr,
        input  coin_req, busy, done, short, fault, remain
    );
endinterface

// File: rtl/change_dispense_sequencer.sv
// Greedy largest-coin-first change dispenser; one req/ack handshake per coin.
// Ports: clk, reset (async active-low), bus (slave: start/change_amt/tube_empty/coin_ack/fault_clr in; coin_req/busy/done/short/fault/remain out).
module change_dispense_sequencer #(
    parameter int AMT_W       = 6,
    parameter int ACK_TIMEOUT = 16,
    parameter int TMR_W       = 5
) (
    input logic                       clk,
    input logic                       reset,
    change_dispense_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SELECT, REQ, DONE, SHORT, FAULT
    } state_t;

    state_t           state;
    logic [AMT_W-1:0] remain_q;
    logic [AMT_W-1:0] coin_val;
    logic [TMR_W-1:0] tmr;
    logic [4:0]       req_q;
    logic             busy_q;
    logic             done_q;
    logic             short_q;
    logic             fault_q;

    logic [4:0]       sel_oh;
    logic [AMT_W-1:0] sel_val;

    // Largest non-empty coin that does not overpay the remaining amount.
    always_comb begin
        sel_oh  = '0;
        sel_val = '0;
        if (!bus.tube_empty[4] && remain_q >= AMT_W'(20)) begin
            sel_oh  = 5'b10000;
            sel_val = AMT_W'(20);
        end else if (!bus.tube_empty[3] && remain_q >= AMT_W'(10)) begin
            sel_oh  = 5'b01000;
            sel_val = AMT_W'(10);
        end else if (!bus.tube_empty[2] && remain_q >= AMT_W'(5)) begin
            sel_oh  = 5'b00100;
            sel_val = AMT_W'(5);
        end else if (!bus.tube_empty[1] && remain_q >= AMT_W'(2)) begin
            sel_oh  = 5'b00010;
            sel_val = AMT_W'(2);
        end else if (!bus.tube_empty[0] && remain_q >= AMT_W'(1)) begin
            sel_oh  = 5'b00001;
            sel_val = AMT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            remain_q <= '0;
            coin_val <= '0;
            tmr      <= '0;
            req_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            short_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            short_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        remain_q <= bus.change_amt;
                        busy_q   <= 1'b1;
                        state    <= SELECT;
                    end
                end
                SELECT: begin
                    if (remain_q == '0) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (sel_oh != '0) begin
                        req_q    <= sel_oh;
                        coin_val <= sel_val;
                        tmr      <= '0;
                        state    <= REQ;
                    end else begin
                        short_q <= 1'b1;
                        state   <= SHORT;
                    end
                end
                REQ: begin
                    // Ack has priority over a coincident timeout.
                    if (bus.coin_ack) begin
                        remain_q <= remain_q - coin_val;
                        req_q    <= '0;
                        state    <= SELECT;
                    end else if (tmr == TMR_W'(ACK_TIMEOUT - 1)) begin
                        req_q   <= '0;
                        fault_q <= 1'b1;
                        state   <= FAULT;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                DONE, SHORT: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                FAULT: begin
                    if (bus.fault_clr) begin
                        fault_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.coin_req = req_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.short    = short_q;
    assign bus.fault    = fault_q;
    assign bus.remain   = remain_q;
endmodule

// File: tb/tb_change_dispense_sequencer.sv
// Randomized bench for change_dispense_sequencer against a greedy coin model.
// Directed cases cover reset, shortfall, ack timeout, mid-op reset and dropped starts.
module tb_change_dispense_sequencer;
    localparam int AMT_W = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    change_dispense_sequencer_if #(.AMT_W(AMT_W)) bus ();

    change_dispense_sequencer #(
        .AMT_W(AMT_W),
        .ACK_TIMEOUT(16),
        .TMR_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int vals[5] = '{1, 2, 5, 10, 20};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input int amt, input logic [4:0] empty,
                           input bit inj);
        logic [4:0] exp_q[$];
        int         rem_after[$];
        int         r;
        int         lat;
        bit         is_short;
        r        = amt;
        is_short = 1'b0;
        while (r > 0) begin
            int pick;
            pick = -1;
            for (int i = 4; i >= 0; i--) begin
                if (!empty[i] && vals[i] <= r) begin
                    pick = i;
                    break;
                end
            end
            if (pick < 0) begin
                is_short = 1'b1;
                break;
            end
            exp_q.push_back(5'(1 << pick));
            r -= vals[pick];
            rem_after.push_back(r);
        end

        @(negedge clk);
        bus.tube_empty = empty;
        bus.change_amt = AMT_W'(amt);
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_sel", 32'(bus.busy), 1);
        @(negedge clk);
        foreach (exp_q[k]) begin
            lat = 0;
            while (bus.coin_req == 5'b0 && lat < 8) begin
                lat++;
                @(negedge clk);
            end
            chk("req_lat", lat, (k == 0) ? 0 : 1);
            chk("coin_req", 32'(bus.coin_req), 32'(exp_q[k]));
            if (inj && k == 0) begin
                bus.start      = 1'b1;
                bus.change_amt = AMT_W'(amt + 7);
                @(negedge clk);
                bus.start      = 1'b0;
                bus.change_amt = AMT_W'(amt);
                chk("req_hold", 32'(bus.coin_req), 32'(exp_q[k]));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus.coin_ack = 1'b1;
            @(negedge clk);
            bus.coin_ack = 1'b0;
            chk("req_drop", 32'(bus.coin_req), 0);
            chk("remain", 32'(bus.remain), rem_after[k]);
        end
        if (exp_q.size() != 0) @(negedge clk);
        chk("done", 32'(bus.done), 32'(!is_short));
        chk("short", 32'(bus.short), 32'(is_short));
        chk("remain_end", 32'(bus.remain), r);
        chk("busy_end", 32'(bus.busy), 1);
        if (inj && exp_q.size() == 0) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("pulse_off", 32'(bus.done | bus.short), 0);
        chk("idle", 32'(bus.busy), 0);
        chk("remain_hold", 32'(bus.remain), r);
    endtask

    task automatic run_fault();
        int cnt;
        @(negedge clk);
        bus.tube_empty = 5'b0;
        bus.change_amt = AMT_W'(5);
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("flt_req", 32'(bus.coin_req), 32'h04);
        cnt = 0;
        while (bus.coin_req == 5'b00100 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("flt_held", cnt, 16);
        chk("flt_fault", 32'(bus.fault), 1);
        chk("flt_req0", 32'(bus.coin_req), 0);
        chk("flt_busy", 32'(bus.busy), 1);
        chk("flt_rem", 32'(bus.remain), 5);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("flt_stay", 32'(bus.fault), 1);
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        chk("clr_fault", 32'(bus.fault), 0);
        chk("clr_busy", 32'(bus.busy), 0);
        chk("clr_rem", 32'(bus.remain), 5);
    endtask

    task automatic run_reset_mid();
        @(negedge clk);
        bus.tube_empty = 5'b0;
        bus.change_amt = AMT_W'(20);
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("rm_req", 32'(bus.coin_req), 32'h10);
        #1 reset = 1'b0;
        #1;
        chk("rm_req0", 32'(bus.coin_req), 0);
        chk("rm_busy", 32'(bus.busy), 0);
        chk("rm_rem", 32'(bus.remain), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.change_amt = '0;
        bus.tube_empty = '0;
        bus.coin_ack   = 1'b0;
        bus.fault_clr  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus.coin_req), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_short", 32'(bus.short), 0);
        chk("rst_fault", 32'(bus.fault), 0);
        chk("rst_rem", 32'(bus.remain), 0);
        reset = 1'b1;

        run_txn(13, 5'b00000, 1'b0);
        run_txn(20, 5'b10000, 1'b0);
        run_txn(3, 5'b00011, 1'b0);
        run_fault();
        run_reset_mid();
        run_txn(20, 5'b00000, 1'b0);
        run_txn(0, 5'b00000, 1'b1);
        run_txn(13, 5'b00000, 1'b1);
        run_txn(63, 5'b00000, 1'b0);
        run_txn(6, 5'b00001, 1'b0);
        repeat (40) begin
            run_txn($urandom_range(0, 63), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
